// File: rtl/rx_top_pkg.sv
// Shared definitions for the UART receive path (common with tx_top).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: default frame width and bit period, and the receiver FSM
// state encodings (3-bit).
package rx_top_pkg;

  localparam int DATA_WIDTH_DEF   = 8;
  localparam int CLKS_PER_BIT_DEF = 16;

  typedef enum logic [2:0] {
    ST_RECOVER = 3'd0,
    ST_IDLE    = 3'd1,
    ST_START   = 3'd2,
    ST_DATA    = 3'd3,
    ST_STOP    = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line plus falling-edge detect.
// Latency: fall asserts 2 RX_CLK edges after the line drops (combinational off the flops).
// Backpressure: none; free-running.
//
// Ports:
//   RX_CLK, RX_RST : receiver clock, synchronous active-high reset
//   RX_DATA        : raw serial line (asynchronous)
//   sync_line      : synchronised line level
//   fall           : one-cycle pulse when sync_line goes 1 -> 0
module uart_rx_sync (
  input  logic RX_CLK,
  input  logic RX_RST,
  input  logic RX_DATA,
  output logic sync_line,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // All stages reset to the idle (high) level so reset itself never looks like an edge.
  always_ff @(posedge RX_CLK) begin
    if (RX_RST) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= RX_DATA;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_line = sync_q;
  assign fall      = prev_q & ~sync_q;

endmodule

// File: rtl/rx_top.sv
// UART receiver: 1 start, DATA_WIDTH data bits LSB first, 1 stop; one-deep valid/ready output.
// Latency: word visible 3 + CLKS_PER_BIT/2 + (DATA_WIDTH+1)*CLKS_PER_BIT cycles after the line falls.
// Backpressure: none on the line; a word completing while the holding register is full and
//               unaccepted is dropped and OVERRUN pulses.
//
// Ports:
//   RX_CLK, RX_RST      : clock, synchronous active-high reset
//   RX_DATA             : serial input, idle high
//   DATA_OUT / RX_VALID : received word and its valid flag; RX_READY accepts it
//   FRAME_ERR, OVERRUN  : one-cycle error pulses
//   RX_BUSY             : frame in progress (START, DATA, STOP)
// CLKS_PER_BIT must be even and at least 4.
module rx_top
  import rx_top_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                  RX_CLK,
  input  logic                  RX_RST,
  input  logic                  RX_DATA,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  RX_VALID,
  input  logic                  RX_READY,
  output logic                  FRAME_ERR,
  output logic                  OVERRUN,
  output logic                  RX_BUSY
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_WIDTH + 1);

  localparam logic [TW-1:0] HALF_M1    = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1    = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] SETTLE_M1  = TW'(2);
  localparam logic [IW-1:0] LAST_IDX   = IW'(DATA_WIDTH - 1);

  logic sync_line;
  logic fall;

  uart_rx_sync u_sync (
    .RX_CLK    (RX_CLK),
    .RX_RST    (RX_RST),
    .RX_DATA   (RX_DATA),
    .sync_line (sync_line),
    .fall      (fall)
  );

  rx_state_t             state;
  logic [TW-1:0]         timer;
  logic [IW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] shreg;

  always_ff @(posedge RX_CLK) begin
    if (RX_RST) begin
      state     <= ST_RECOVER;
      timer     <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      DATA_OUT  <= '0;
      RX_VALID  <= 1'b0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
      RX_BUSY   <= 1'b0;
    end else begin
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;

      // Consumer handshake; a load in STOP below overrides this in the same cycle.
      if (RX_VALID && RX_READY) begin
        RX_VALID <= 1'b0;
      end

      unique case (state)
        ST_RECOVER: begin
          // The synchroniser's reset value of 1 is not evidence of an idle line, so the
          // high level must persist long enough to have flushed through both flops and
          // the edge detector before a falling edge can be trusted.
          if (!sync_line) begin
            timer <= '0;
          end else if (timer == SETTLE_M1) begin
            timer <= '0;
            state <= ST_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_IDLE: begin
          if (fall) begin
            state   <= ST_START;
            timer   <= '0;
            RX_BUSY <= 1'b1;
          end
        end

        ST_START: begin
          if (timer == HALF_M1) begin
            timer <= '0;
            if (sync_line) begin
              // Line went back high before mid-bit: a glitch, not a start bit.
              state   <= ST_IDLE;
              RX_BUSY <= 1'b0;
            end else begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_DATA: begin
          if (timer == FULL_M1) begin
            timer <= '0;
            shreg <= {sync_line, shreg[DATA_WIDTH-1:1]};
            if (bit_idx == LAST_IDX) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_STOP: begin
          if (timer == FULL_M1) begin
            timer   <= '0;
            RX_BUSY <= 1'b0;
            if (sync_line) begin
              state <= ST_IDLE;
              if (!RX_VALID || RX_READY) begin
                DATA_OUT <= shreg;
                RX_VALID <= 1'b1;
              end else begin
                OVERRUN <= 1'b1;
              end
            end else begin
              // Line is still low: wait for it to go idle before hunting for a start bit.
              state     <= ST_RECOVER;
              FRAME_ERR <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: begin
          state   <= ST_RECOVER;
          timer   <= '0;
          RX_BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rx_top.md
Name: rx_top

Overview:
UART receiver that consumes the serial stream produced by tx_top on the TX_DATA line. It deserialises frames of 1 start bit (0), DATA_WIDTH data bits sent LSB first, and 1 stop bit (1), with idle high. Received words go to the consumer through a one-deep valid/ready holding register. Framing errors and overruns are flagged.

Parameters:
DATA_WIDTH, 8 (`DATA_WIDTH from uart_params.vh), data bits per frame
CLKS_PER_BIT, 16, RX_CLK cycles per serial bit; must be ≥4 and even; must match the transmitter bit period

Ports:
RX_CLK  input  1  receiver clock; all logic is on the rising edge
RX_RST  input  1  synchronous, active-high reset
RX_DATA  input  1  serial line from tx_top TX_DATA; asynchronous to RX_CLK; idle high
DATA_OUT  output  DATA_WIDTH  received word; stable while RX_VALID=1
RX_VALID  output  1  holding register contains an unread word
RX_READY  input  1  consumer accepts DATA_OUT when RX_VALID && RX_READY
FRAME_ERR  output  1  one-cycle pulse: stop bit sampled as 0
OVERRUN  output  1  one-cycle pulse: a completed word was dropped
RX_BUSY  output  1  high in START, DATA and STOP

Behaviour:
- Interface: one clock, RX_CLK. Reset RX_RST is synchronous and active-high.
- Input path: 2-flop synchroniser on RX_DATA, then a falling-edge detector (prev=1, cur=0). Synchroniser flops reset to 1.
- Reset values: DATA_OUT=0, RX_VALID=0, FRAME_ERR=0, OVERRUN=0, RX_BUSY=0. Counters are cleared.
- Reset entry state is RECOVER. A line held low through reset is not taken as a start bit.
- Reset asserted mid-frame aborts the frame. No partial word is delivered.
- FSM states and transitions:
  - RECOVER: wait until the synced line is 1, then go to IDLE.
  - IDLE: on a synced falling edge at cycle t0, go to START and clear the bit-timer.
  - START: at t0+CLKS_PER_BIT/2, sample the line. If 1, treat it as a glitch and return to IDLE. If 0, go to DATA with bit index 0.
  - DATA: every CLKS_PER_BIT cycles, sample into a shift register, LSB first. Bit i is sampled at t0+CLKS_PER_BIT/2+(i+1)*CLKS_PER_BIT. After bit DATA_WIDTH-1, go to STOP.
  - STOP: sample at t0+CLKS_PER_BIT/2+(DATA_WIDTH+1)*CLKS_PER_BIT.
    - If the sample is 1: deliver the word and go to IDLE.
    - If the sample is 0: pulse FRAME_ERR on the next cycle, deliver nothing, go to RECOVER.
- Delivery rules (word is written to DATA_OUT and RX_VALID rises one cycle after the stop sample):
  - Holding register empty: load the word and set RX_VALID.
  - RX_VALID=1 and RX_READY=1 in the same cycle: the old word is consumed, the new word loads, RX_VALID stays 1.
  - RX_VALID=1 and RX_READY=0: the new word is dropped, DATA_OUT is kept, OVERRUN pulses one cycle.
- Handshake:
  - RX_VALID stays high until a cycle with RX_READY=1. It clears on the next edge unless a new word loads in that same cycle.
  - RX_READY with RX_VALID=0 has no effect.
- Widths:
  - Bit-timer is $clog2(CLKS_PER_BIT) bits and wraps to 0 at CLKS_PER_BIT-1.
  - Bit index is $clog2(DATA_WIDTH+1) bits.
- Back-to-back frames: a falling edge may be detected on the first cycle after STOP returns to IDLE. No extra idle bit is required beyond the stop bit.

Decomposition:
- uart_params.vh (shared with tx_top) holds:
  - `DATA_WIDTH
  - `CLKS_PER_BIT default
  - FSM state encodings: RECOVER, IDLE, START, DATA, STOP (3-bit localparams)
- One sub-module, uart_rx_sync: 2-flop synchroniser plus falling-edge detect. Outputs are the synced line and a fall pulse. It uses the same RX_CLK/RX_RST.

Test Plan:
1. Basic frame. Reset for 2 cycles, line idle 1, then send 8'hAA LSB first (0,1,0,1,0,1,0,1), stop 1, at 16 clk/bit, RX_READY=1 → single RX_VALID cycle with DATA_OUT=8'hAA; FRAME_ERR=0 and OVERRUN=0 throughout.
2. Glitch rejection. Pull the line low for 5 cycles, then back high → FSM returns to IDLE; RX_BUSY pulses, RX_VALID stays 0.
3. Framing error. Send 8'h55 with stop bit 0, held low for 2 more bits → FRAME_ERR pulses 1 cycle, RX_VALID stays 0. The next valid 8'h3C frame after the line returns high is received correctly.
4. Overrun. RX_READY=0, send 8'h11 then 8'h22 back-to-back → DATA_OUT=8'h11 with RX_VALID=1, and OVERRUN pulses after the second stop bit. Raising RX_READY clears RX_VALID; DATA_OUT is still 8'h11.
5. Simultaneous accept and load. Hold 8'h11 unread, and assert RX_READY exactly on the cycle 8'h22 completes → RX_VALID stays 1, DATA_OUT=8'h22, no OVERRUN.
6. Reset mid-frame and low line at reset.
   - Assert RX_RST during DATA bit 3 → all outputs return to 0 and no word is delivered.
   - Hold the line 0 through reset, then release high → no spurious frame; the next 8'hF0 is received.
